usb_rx_data_buffer: RTL and testbench
=====================================

// Module: usb_rx_data_buffer
// PURPOSE
//  - 64-byte receive data FIFO directly downstream of the USB RX controller.
//  - Accepts payload bytes on store_rx_pd / rx_packet_data and honours the controller's flush.
//  - Returns occupancy on buff_ocp, which feeds back into the RX controller.
//  - Host/AHB side drains bytes with get_rx_data; sticky overflow/underflow flags go to the status register.
// PARAMETERS
//  - DEPTH   64  number of byte entries; power of two
//  - ADDR_W  6   pointer width, log2(DEPTH)
//  - DATA_W  8   entry width
//  - HWM     48  high-watermark level; used only with USB_RXBUF_HWM_EN
// PORTS
//  - clk            in   1       system clock; single clock domain
//  - n_rst          in   1       reset; asynchronous, active-low
//  - flush          in   1       sync clear from RX controller
//  - clear          in   1       sync clear from host
//  - store_rx_pd    in   1       write strobe; 1 byte per asserted cycle
//  - rx_packet_data in   DATA_W  write data
//  - get_rx_data    in   1       read/pop strobe from host side
//  - rx_data        out  DATA_W  head entry (show-ahead)
//  - buff_ocp       out  ADDR_W+1  occupancy, 0..DEPTH
//  - buff_empty     out  1       buff_ocp==0
//  - buff_full      out  1       buff_ocp==DEPTH
//  - ovf_err        out  1       sticky: write attempted while full
//  - udf_err        out  1       sticky: read attempted while empty
//  - buff_hwm       out  1       registered, buff_ocp>=HWM; present only with USB_RXBUF_HWM_EN
// BEHAVIOUR
//  - Reset (n_rst=0, async):
//    - wr_ptr=rd_ptr=0; buff_ocp=0; buff_empty=1; buff_full=0.
//    - ovf_err=0; udf_err=0; buff_hwm=0.
//    - All entries cleared to 0, so rx_data=8'h00.
//  - Reset applied mid-packet discards everything; no partial state survives.
//  - Control FSM, 3 states:
//    - EMPTY: ocp==0.
//    - ACTIVE: 0<ocp<DEPTH.
//    - FULL: ocp==DEPTH.
//    - Next state derives from next ocp; buff_empty and buff_full are decoded from the registered state.
//  - Priority per cycle: flush|clear > write/read.
//    - flush or clear: pointers and ocp go to 0, state goes to EMPTY, both error flags go to 0.
//    - Same-cycle store_rx_pd and get_rx_data are ignored.
//    - Stored entries are not zeroed.
//  - Write (store_rx_pd=1, not full): mem[wr_ptr]<=rx_packet_data; wr_ptr+1 (wraps DEPTH-1 -> 0); ocp+1.
//  - Read (get_rx_data=1, not empty): rd_ptr+1 (wraps); ocp-1.
//    - rx_data = mem[rd_ptr] combinationally, so the popped byte is valid in the same cycle as the strobe.
//    - rx_data is don't-care while empty.
//  - Simultaneous write+read:
//    - ACTIVE: both performed; ocp unchanged.
//    - FULL: both performed; ocp stays DEPTH and the write is not an overflow.
//    - EMPTY: read rejected (udf_err<=1), write accepted; ocp=1 next cycle. No write-through bypass.
//  - Write while FULL without a read: data dropped, pointers unchanged, ovf_err<=1.
//  - Read while EMPTY: pointers unchanged, udf_err<=1.
//  - Error flags stay set until flush or clear.
//  - Latency:
//    - buff_ocp and flags update the cycle after the strobe.
//    - A written byte appears on rx_data the cycle after the write when the FIFO was empty.
//  - Pointer arithmetic: ADDR_W-bit modulo wrap; ocp is ADDR_W+1 bits and never exceeds DEPTH.
// CONFIGURATION
//  - USB_RXBUF_HWM_EN defined:
//    - buff_hwm port exists.
//    - Register set to (next ocp >= HWM); reset 0; cleared on flush/clear.
//  - USB_RXBUF_HWM_EN undefined:
//    - No buff_hwm port, no HWM logic.
//    - HWM parameter is ignored.
// STRUCTURE
//  - Shared package usb_pkg holds:
//    - RXBUF_DEPTH and RXBUF_ADDR_W constants.
//    - Buffer state enum {BUF_EMPTY, BUF_ACTIVE, BUF_FULL}.
//    - The 3-bit rx_packet PID encodings shared with the RX controller.
//  - Sub-module usb_rxbuf_regfile:
//    - DEPTH x DATA_W register array with reset.
//    - 1 synchronous write port, 1 asynchronous read port.
//  - Pointers, occupancy, FSM and flags stay in the top module.
// TESTING
//  - Reset, then 3 writes 8'hA1,8'hB2,8'hC3 -> buff_ocp=3; pops return A1,B2,C3 in order; buff_empty=1 afterwards.
//  - 64 writes of 0..63 -> buff_full=1, ocp=64; 65th write 8'hFF -> ovf_err=1, ocp=64; drain returns 0..63, no FF.
//  - Pop on empty -> udf_err=1, ocp=0; same cycle also store 8'h5A -> ocp=1, rx_data=8'h5A.
//  - Fill to 64, then simultaneous store+pop for 10 cycles -> ocp stays 64, no ovf_err; pointer wrap verified across index 63->0.
//  - 20 bytes stored, flush asserted together with store_rx_pd -> next cycle ocp=0, errors 0, write ignored; repeat with clear.
//  - USB_RXBUF_HWM_EN build: 47 writes -> buff_hwm=0; 48th -> buff_hwm=1 next cycle; one pop -> 0; async n_rst mid-fill -> all outputs at reset values.

Source files
------------

// File: rtl/usb_pkg.sv
// usb_pkg
//   Definitions shared by the USB receive path: receive-buffer geometry, the
//   receive-buffer state encoding and the 3-bit rx_packet PID encodings that
//   the RX controller and the receive buffer both use.
//   No ports (package only).
package usb_pkg;

    localparam int RXBUF_DEPTH  = 64;
    localparam int RXBUF_ADDR_W = 6;
    localparam int RXBUF_DATA_W = 8;
    localparam int RXBUF_HWM    = 48;

    // Receive buffer control state. The name of each state matches its occupancy band.
    typedef enum logic [1:0] {
        BUF_EMPTY  = 2'd0,
        BUF_ACTIVE = 2'd1,
        BUF_FULL   = 2'd2
    } buf_state_e;

    // rx_packet identifiers as decoded by the RX controller.
    typedef enum logic [2:0] {
        RX_PID_NONE  = 3'd0,
        RX_PID_OUT   = 3'd1,
        RX_PID_IN    = 3'd2,
        RX_PID_SETUP = 3'd3,
        RX_PID_DATA0 = 3'd4,
        RX_PID_DATA1 = 3'd5,
        RX_PID_ACK   = 3'd6,
        RX_PID_NAK   = 3'd7
    } rx_pid_e;

endpackage

// File: rtl/usb_rxbuf_regfile.sv
// usb_rxbuf_regfile
//   DEPTH x DATA_W storage for the receive buffer. It has one synchronous
//   write port and one asynchronous read port. Every entry resets to zero,
//   so the read port shows 0 after reset.
//   Ports:
//     clk, n_rst       clock, asynchronous active-low reset
//     wr_en            write strobe
//     wr_addr/wr_data  write address and data
//     rd_addr          read address
//     rd_data          mem[rd_addr], combinational
module usb_rxbuf_regfile #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/usb_rx_data_buffer.sv
// usb_rx_data_buffer
//   A 64-byte receive data FIFO that sits directly after the USB RX
//   controller. The head entry is shown ahead on rx_data. The occupancy
//   output feeds back to the RX controller. The overflow and underflow flags
//   are sticky and go to the status register.
//   Optional feature: define USB_RXBUF_HWM_EN to add the registered
//   high-watermark output buff_hwm and its HWM parameter.
//   Ports:
//     clk, n_rst       clock, asynchronous active-low reset
//     flush, clear     synchronous clear inputs, from the RX controller and from the host
//     store_rx_pd      write strobe, rx_packet_data  write byte
//     get_rx_data      pop strobe, rx_data  head entry
//     buff_ocp         occupancy 0..DEPTH
//     buff_empty/full  decoded from the registered control state
//     ovf_err/udf_err  sticky error flags
//     buff_state       control state, exported for observation
//     buff_hwm         (USB_RXBUF_HWM_EN only) registered occupancy >= HWM
//
//   Strobe semantics: neither side has back-pressure. Each cycle with
//   store_rx_pd high offers one byte, and each cycle with get_rx_data high
//   consumes the byte currently on rx_data. A byte offered while the buffer
//   is full is dropped and raises ovf_err. A pop while the buffer is empty is
//   ignored and raises udf_err. When flush or clear is high, both strobes are
//   ignored for that cycle.
module usb_rx_data_buffer
    import usb_pkg::*;
#(
    parameter int DEPTH  = RXBUF_DEPTH,
    parameter int ADDR_W = RXBUF_ADDR_W,
    parameter int DATA_W = RXBUF_DATA_W
`ifdef USB_RXBUF_HWM_EN
    ,
    parameter int HWM    = RXBUF_HWM
`endif
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              flush,
    input  logic              clear,
    input  logic              store_rx_pd,
    input  logic [DATA_W-1:0] rx_packet_data,
    input  logic              get_rx_data,
    output logic [DATA_W-1:0] rx_data,
    output logic [ADDR_W:0]   buff_ocp,
    output logic              buff_empty,
    output logic              buff_full,
    output logic              ovf_err,
    output logic              udf_err,
`ifdef USB_RXBUF_HWM_EN
    output logic              buff_hwm,
`endif
    output buf_state_e        buff_state
);

    localparam int OCP_W = ADDR_W + 1;

    buf_state_e        state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCP_W-1:0]  ocp_q, ocp_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;
    logic              sclr;
    logic              do_wr, do_rd;

    assign sclr = flush | clear;

    // A pop is accepted whenever data is present. A write is accepted when
    // there is room, or when the buffer is full but a pop frees a slot in the
    // same cycle. An empty buffer never bypasses a write straight to the read side.
    assign do_rd = !sclr && get_rx_data && (state_q != BUF_EMPTY);
    assign do_wr = !sclr && store_rx_pd && ((state_q != BUF_FULL) || do_rd);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ocp_d    = ocp_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        if (sclr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            ocp_d    = '0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end else begin
            if (do_wr) begin
                wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            end
            if (do_rd) begin
                rd_ptr_d = rd_ptr_q + ADDR_W'(1);
            end
            ocp_d = ocp_q + OCP_W'(do_wr) - OCP_W'(do_rd);
            if (store_rx_pd && !do_wr) begin
                ovf_d = 1'b1;
            end
            if (get_rx_data && !do_rd) begin
                udf_d = 1'b1;
            end
        end
    end

    // The next state is derived from the next occupancy, so the state always
    // names the band that ocp_q is in.
    always_comb begin
        state_d = BUF_ACTIVE;
        if (ocp_d == '0) begin
            state_d = BUF_EMPTY;
        end else if (ocp_d == OCP_W'(DEPTH)) begin
            state_d = BUF_FULL;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= BUF_EMPTY;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ocp_q    <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ocp_q    <= ocp_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

`ifdef USB_RXBUF_HWM_EN
    logic hwm_q;

    // On flush or clear, ocp_d is zero, so this register clears as well.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            hwm_q <= 1'b0;
        end else begin
            hwm_q <= (ocp_d >= OCP_W'(HWM));
        end
    end

    assign buff_hwm = hwm_q;
`endif

    usb_rxbuf_regfile #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_regfile (
        .clk     (clk),
        .n_rst   (n_rst),
        .wr_en   (do_wr),
        .wr_addr (wr_ptr_q),
        .wr_data (rx_packet_data),
        .rd_addr (rd_ptr_q),
        .rd_data (rx_data)
    );

    assign buff_ocp   = ocp_q;
    assign buff_empty = (state_q == BUF_EMPTY);
    assign buff_full  = (state_q == BUF_FULL);
    assign ovf_err    = ovf_q;
    assign udf_err    = udf_q;
    assign buff_state = state_q;

endmodule

// File: tb/tb_usb_rx_data_buffer.sv
module tb_usb_rx_data_buffer;
    import usb_pkg::*;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       flush = 1'b0;
    logic       clear = 1'b0;
    logic       store_rx_pd = 1'b0;
    logic [7:0] rx_packet_data = 8'h00;
    logic       get_rx_data = 1'b0;
    logic [7:0] rx_data;
    logic [6:0] buff_ocp;
    logic       buff_empty;
    logic       buff_full;
    logic       ovf_err;
    logic       udf_err;
    buf_state_e buff_state;
`ifdef USB_RXBUF_HWM_EN
    logic       buff_hwm;
`endif

    int n_checks = 0;
    int n_fail = 0;
    logic [7:0] exp_q[$];

    usb_rx_data_buffer dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .flush          (flush),
        .clear          (clear),
        .store_rx_pd    (store_rx_pd),
        .rx_packet_data (rx_packet_data),
        .get_rx_data    (get_rx_data),
        .rx_data        (rx_data),
        .buff_ocp       (buff_ocp),
        .buff_empty     (buff_empty),
        .buff_full      (buff_full),
        .ovf_err        (ovf_err),
        .udf_err        (udf_err),
`ifdef USB_RXBUF_HWM_EN
        .buff_hwm       (buff_hwm),
`endif
        .buff_state     (buff_state)
    );

    // Clock and reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a pop accepted by the DUT presents its byte on rx_data during the strobe cycle.
    always @(negedge clk) begin
        if (n_rst && get_rx_data && !flush && !clear && !buff_empty) begin
            if (exp_q.size() == 0) begin
                check("pop_unexpected", 32'(rx_data), 32'hFFFF_FFFF);
            end else begin
                check("pop_data", 32'(rx_data), 32'(exp_q.pop_front()));
            end
        end
    end

    // Driver: the caller starts at posedge+1. The strobes are held for one
    // cycle and then dropped at the next posedge+1.
    task automatic tick(input logic st, input logic [7:0] d, input logic gt,
                        input logic fl, input logic cl);
        store_rx_pd    = st;
        rx_packet_data = d;
        get_rx_data    = gt;
        flush          = fl;
        clear          = cl;
        @(posedge clk);
        #1;
        store_rx_pd = 1'b0;
        get_rx_data = 1'b0;
        flush       = 1'b0;
        clear       = 1'b0;
    endtask

    task automatic wr(input logic [7:0] d, input bit expect_kept);
        if (expect_kept) exp_q.push_back(d);
        tick(1'b1, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop();
        tick(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        exp_q.delete();
        n_rst = 1'b0;
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        do_reset();
        check("rst_ocp", 32'(buff_ocp), 32'd0);
        check("rst_empty", 32'(buff_empty), 32'd1);
        check("rst_full", 32'(buff_full), 32'd0);
        check("rst_errs", {30'd0, ovf_err, udf_err}, 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'h00);
        check("rst_state", 32'(buff_state), 32'(BUF_EMPTY));

        // Three bytes in order
        wr(8'hA1, 1'b1);
        wr(8'hB2, 1'b1);
        wr(8'hC3, 1'b1);
        check("three_ocp", 32'(buff_ocp), 32'd3);
        check("three_state", 32'(buff_state), 32'(BUF_ACTIVE));
        for (int i = 0; i < 3; i++) pop();
        check("three_empty", 32'(buff_empty), 32'd1);
        check("three_ocp0", 32'(buff_ocp), 32'd0);

        // Fill, overflow, drain
        for (int i = 0; i < 64; i++) wr(8'(i), 1'b1);
        check("fill_full", 32'(buff_full), 32'd1);
        check("fill_ocp", 32'(buff_ocp), 32'd64);
        check("fill_no_ovf", 32'(ovf_err), 32'd0);
        wr(8'hFF, 1'b0);
        check("ovf_flag", 32'(ovf_err), 32'd1);
        check("ovf_ocp", 32'(buff_ocp), 32'd64);
        for (int i = 0; i < 64; i++) pop();
        check("drain_empty", 32'(buff_empty), 32'd1);
        check("ovf_sticky", 32'(ovf_err), 32'd1);
        tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("clear_ovf", 32'(ovf_err), 32'd0);

        // Underflow, then a pop on empty together with a store
        pop();
        check("udf_flag", 32'(udf_err), 32'd1);
        check("udf_ocp", 32'(buff_ocp), 32'd0);
        exp_q.push_back(8'h5A);
        tick(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
        check("udfw_ocp", 32'(buff_ocp), 32'd1);
        check("udfw_rx_data", 32'(rx_data), 32'h5A);
        check("udfw_udf", 32'(udf_err), 32'd1);
        pop();
        tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Full with a store and a pop in the same cycle; wr_ptr and then rd_ptr wrap
        for (int i = 0; i < 64; i++) wr(8'h80 + 8'(i), 1'b1);
        for (int k = 0; k < 10; k++) begin
            exp_q.push_back(8'h40 + 8'(k));
            tick(1'b1, 8'h40 + 8'(k), 1'b1, 1'b0, 1'b0);
            check("rw_full_ocp", 32'(buff_ocp), 32'd64);
        end
        check("rw_full_no_ovf", 32'(ovf_err), 32'd0);
        check("rw_full_flag", 32'(buff_full), 32'd1);
        for (int i = 0; i < 64; i++) pop();
        check("rw_drain_empty", 32'(buff_empty), 32'd0 + 32'd1);

        // A flush, and then a clear, wins over a store in the same cycle
        for (int rep = 0; rep < 2; rep++) begin
            pop();
            check("pre_sclr_udf", 32'(udf_err), 32'd1);
            for (int i = 0; i < 20; i++) tick(1'b1, 8'(i + 1), 1'b0, 1'b0, 1'b0);
            check("pre_sclr_ocp", 32'(buff_ocp), 32'd20);
            tick(1'b1, 8'h77, rep == 1, rep == 0, rep == 1);
            check("sclr_ocp", 32'(buff_ocp), 32'd0);
            check("sclr_empty", 32'(buff_empty), 32'd1);
            check("sclr_errs", {30'd0, ovf_err, udf_err}, 32'd0);
            tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
            check("sclr_write_ignored", 32'(buff_ocp), 32'd0);
        end

`ifdef USB_RXBUF_HWM_EN
        for (int i = 0; i < 47; i++) wr(8'(i), 1'b1);
        check("hwm_47", 32'(buff_hwm), 32'd0);
        wr(8'd47, 1'b1);
        check("hwm_48", 32'(buff_hwm), 32'd1);
        pop();
        check("hwm_pop", 32'(buff_hwm), 32'd0);
        wr(8'hEE, 1'b1);
        check("hwm_again", 32'(buff_hwm), 32'd1);
`endif

        // Asynchronous reset while a packet is being stored
        for (int i = 0; i < 5; i++) tick(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0, 1'b0);
        store_rx_pd    = 1'b1;
        rx_packet_data = 8'h99;
        #2;
        n_rst = 1'b0;
        exp_q.delete();
        #1;
        check("arst_ocp", 32'(buff_ocp), 32'd0);
        check("arst_empty_full", {30'd0, buff_empty, buff_full}, 32'd2);
        check("arst_errs", {30'd0, ovf_err, udf_err}, 32'd0);
        check("arst_rx_data", 32'(rx_data), 32'h00);
`ifdef USB_RXBUF_HWM_EN
        check("arst_hwm", 32'(buff_hwm), 32'd0);
`endif
        store_rx_pd = 1'b0;
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        @(posedge clk);
        #1;
        check("post_arst_ocp", 32'(buff_ocp), 32'd0);

        check("sb_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
